// File: rtl/stream_pattern_gen_pkg.sv
// rtl/stream_pattern_gen_pkg.sv - shared states, pattern modes and PRBS31 taps for stream_pattern_gen
package stream_pattern_gen_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PKT  = 3'd2,
        GAP  = 3'd3,
        END  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_FIXED = 2'd0;
    localparam logic [1:0] MODE_INC   = 2'd1;
    localparam logic [1:0] MODE_PRBS  = 2'd2;

    // Polynomial x^31 + x^28 + 1 as 1-based tap positions
    localparam int PRBS_TAP_A = 31;
    localparam int PRBS_TAP_B = 28;

endpackage

// File: rtl/stream_pattern_core.sv
// rtl/stream_pattern_core.sv - per-packet word pattern state (fixed / increment / PRBS31 under STREAM_PATTERN_GEN_PRBS_EN)
module stream_pattern_core
    import stream_pattern_gen_pkg::*;
#(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [DATA_W-1:0] inc,
    input  logic              load,
    input  logic              advance,
    output logic [DATA_W-1:0] word
);

    logic [DATA_W-1:0] acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (load) begin
            acc <= seed;
        end else if (advance && mode == MODE_INC) begin
            acc <= acc + inc;
        end
    end

`ifdef STREAM_PATTERN_GEN_PRBS_EN
    localparam int REP = (DATA_W + 31) / 32;

    logic [30:0]       lfsr;
    logic [REP*32-1:0] prbs_rep;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 31'd1;
        end else if (load) begin
            // An all-zero LFSR would lock up, so a zero seed becomes 1
            lfsr <= (seed[30:0] == 31'd0) ? 31'd1 : seed[30:0];
        end else if (advance && mode == MODE_PRBS) begin
            lfsr <= {lfsr[29:0], lfsr[PRBS_TAP_A-1] ^ lfsr[PRBS_TAP_B-1]};
        end
    end

    assign prbs_rep = {REP{{1'b0, lfsr}}};
    assign word     = (mode == MODE_PRBS) ? prbs_rep[DATA_W-1:0] : acc;
`else
    assign word = acc;
`endif

endmodule

// File: rtl/stream_pattern_gen.sv
// rtl/stream_pattern_gen.sv - non-FWFT FIFO-read packet train source; PRBS mode under STREAM_PATTERN_GEN_PRBS_EN
module stream_pattern_gen
    import stream_pattern_gen_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cfg_mode,
    input  logic [DATA_W-1:0] cfg_start_from,
    input  logic [DATA_W-1:0] cfg_inc,
    input  logic [CNT_W-1:0]  cfg_pkt_len,
    input  logic [CNT_W-1:0]  cfg_pkt_gap,
    input  logic [CNT_W-1:0]  cfg_pkt_num,
    input  logic              stream_start,
    input  logic              stream_stop,
    output logic              stream_busy,
    input  logic              fifo_rd,
    output logic              fifo_empty,
    output logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_last,
    output logic [CNT_W-1:0]  pkt_done_cnt
);

    state_t            state, state_nxt;
    logic [1:0]        sh_mode;
    logic [DATA_W-1:0] sh_seed, sh_inc;
    logic [CNT_W-1:0]  sh_len_m1, sh_gap, sh_num;
    logic [CNT_W-1:0]  word_cnt, gap_cnt, done_inc;
    logic              stop_pend;
    logic              rd_acc, last_word, core_load;
    logic [DATA_W-1:0] core_word;

    assign fifo_empty  = (state != PKT);
    assign stream_busy = (state != IDLE);
    assign rd_acc      = fifo_rd & ~fifo_empty;
    assign last_word   = (word_cnt == sh_len_m1);
    assign done_inc    = (pkt_done_cnt == '1) ? pkt_done_cnt : pkt_done_cnt + CNT_W'(1);
    // Reloading on the last read restarts the pattern for the next packet, even across a gap
    assign core_load   = (state == LOAD) | (rd_acc & last_word);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (stream_start) state_nxt = LOAD;
            LOAD: state_nxt = PKT;
            PKT: begin
                if (rd_acc && last_word) begin
                    if ((sh_num != '0 && done_inc == sh_num) || stop_pend || stream_stop) begin
                        state_nxt = END;
                    end else if (sh_gap != '0) begin
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (stream_stop) begin
                    state_nxt = END;
                end else if (gap_cnt == sh_gap) begin
                    state_nxt = PKT;
                end
            end
            END:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_mode      <= MODE_FIXED;
            sh_seed      <= '0;
            sh_inc       <= '0;
            sh_len_m1    <= '0;
            sh_gap       <= '0;
            sh_num       <= '0;
            word_cnt     <= '0;
            gap_cnt      <= CNT_W'(1);
            stop_pend    <= 1'b0;
            fifo_dout    <= '0;
            fifo_last    <= 1'b0;
            pkt_done_cnt <= '0;
        end else begin
            if (state == IDLE && stream_start) begin
                sh_mode      <= cfg_mode;
                sh_seed      <= cfg_start_from;
                sh_inc       <= cfg_inc;
                sh_len_m1    <= (cfg_pkt_len == '0) ? '0 : cfg_pkt_len - CNT_W'(1);
                sh_gap       <= cfg_pkt_gap;
                sh_num       <= cfg_pkt_num;
                pkt_done_cnt <= '0;
            end
            if (state == LOAD || state == PKT) begin
                stop_pend <= stop_pend | stream_stop;
            end else begin
                stop_pend <= 1'b0;
            end
            gap_cnt <= (state == GAP) ? gap_cnt + CNT_W'(1) : CNT_W'(1);
            if (state == LOAD) begin
                word_cnt <= '0;
            end
            if (rd_acc) begin
                fifo_dout <= core_word;
                fifo_last <= last_word;
                word_cnt  <= last_word ? '0 : word_cnt + CNT_W'(1);
                if (last_word) begin
                    pkt_done_cnt <= done_inc;
                end
            end
        end
    end

    stream_pattern_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .mode    (sh_mode),
        .seed    (sh_seed),
        .inc     (sh_inc),
        .load    (core_load),
        .advance (rd_acc),
        .word    (core_word)
    );

endmodule
